board_buttons: RTL and testbench
================================

# board_buttons

Front-panel button conditioner that produces the `start`, `stop` and `inc` inputs consumed by the board run/stop/single-step controller. It takes three raw, asynchronous, bouncing push-button inputs and synchronizes and debounces each one. It outputs clean registered levels with a fixed priority (stop > start > inc), plus optional one-cycle press pulses. It sits between the board pins and the CPU control FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 4, is the number of consecutive synchronized samples that must disagree with the current stable level before that level flips. Legal values are 1..65535.
- `clock`, input, 1: system clock, rising edge.
- `reset`, input, 1: reset, synchronous, active-low.
- `start_btn`, input, 1: raw start button, active-high, asynchronous.
- `stop_btn`, input, 1: raw stop button, active-high, asynchronous.
- `inc_btn`, input, 1: raw single-step button, active-high, asynchronous.
- `start`, output, 1: debounced, priority-masked start level.
- `stop`, output, 1: debounced stop level.
- `inc`, output, 1: debounced, priority-masked single-step level. It is held while the button is held, so the controller can wait for release.
- `start_pulse`, `stop_pulse`, `inc_pulse`, output, 1 each: one-cycle rising-edge pulses of the masked levels. These exist only with `BTN_PULSE_EN` defined.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer. The first flop of each synchronizer resets to 0.
- **Debounce, per button:** the cell holds a stable level `lvl` and a counter `cnt`, each reset to 0.
  - If the synchronized sample equals `lvl`, then `cnt` is set to 0.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `lvl` is set to the sample and `cnt` is set to 0.
  - Otherwise `cnt` increments by 1.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`, with a minimum of 1. `cnt` never wraps because it is cleared on reaching the limit.
- **Priority masking:** outputs are computed from the next-state `lvl` values and registered.
  - `stop` = stop_lvl.
  - `start` = start_lvl & ~stop_lvl.
  - `inc` = inc_lvl & ~start_lvl & ~stop_lvl.
- **Pulses:** `x_pulse` is high for exactly the one cycle in which masked `x` goes 0→1. There is no pulse on a falling edge.
- **Unmasking:** when a masking button is released while a masked button is still held, the masked output rises and its pulse fires. Example: stop is released while start is held, so `start` rises and `start_pulse` fires.
- **Reset:** every output, synchronizer flop, `lvl` and `cnt` is 0 while `reset` is low. A press already under way when reset releases restarts debounce from `cnt = 0`.

## Timing
- **Latency:** the raw change is sampled at edge 1 and visible after edge 2. The first differing sample counts at edge 3. The output changes at edge `2+DEBOUNCE_CYCLES`. That is 6 edges at the default.
- **Release latency:** identical to press latency.
- **Glitch rejection:** any run of differing samples shorter than `DEBOUNCE_CYCLES` produces no output change.
- **Simultaneous flips:** buttons that flip on the same edge are masked in that same cycle. No transient `start` appears with `stop`.

## Configuration
- `BTN_PULSE_EN` defined:
  - The three `_pulse` ports are present.
  - One extra register per masked output holds the previous value.
- `BTN_PULSE_EN` undefined:
  - The `_pulse` ports and their registers are absent.
  - Level behaviour is identical.

## Structure
- **Package `board_pkg`:**
  - Button index constants: `BTN_START=0`, `BTN_STOP=1`, `BTN_INC=2`, `BTN_NUM=3`.
  - Counter-width function `debounce_w(cycles)`.
  - Default `DEBOUNCE_CYCLES` constant.
- **Sub-module `debounce_cell`:**
  - Contains the synchronizer, counter and `lvl` for one button.
  - Parameterized by `DEBOUNCE_CYCLES`.
  - Exposes `lvl_next` and `lvl`.
  - The top level instantiates three and adds masking and pulse logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `BTN_PULSE_EN` defined.
- **Clean press:** `start_btn` goes 1 before edge 1 and is held for 20 cycles → `start` is 1 after edge 6, `start_pulse` is high only during cycle 6–7, and `stop=inc=0`.
- **Bounce rejection:** `inc_btn` toggles every 2 cycles for 16 cycles, then returns to 0 → `inc` and `inc_pulse` stay 0 throughout.
- **Priority:** `start_btn` and `stop_btn` rise together → `stop=1` and `start=0` after edge 6, with only `stop_pulse` firing. Then `stop_btn` releases → `start` rises 6 edges later with `start_pulse`.
- **Held single-step:** `inc_btn` is held for 30 cycles, then released → `inc` is high from edge 6 and falls 6 edges after release. There is one pulse total.
- **Reset mid-debounce:** `stop_btn` rises, then `reset` is low for 1 cycle at edge 4 → all outputs are 0, and `stop` rises only at the 6th edge after reset returns high.
- **Minimum parameter:** with `DEBOUNCE_CYCLES=1`, a single-cycle raw pulse on `start_btn` → `start` is high for exactly one cycle after edge 3.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared constants for the front-panel button conditioner.
// Button indices, default debounce length and counter-width helper.
package board_pkg;

    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_STOP  = 1;
    localparam int unsigned BTN_INC   = 2;
    localparam int unsigned BTN_NUM   = 3;

    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    // Counter must hold 0..cycles-1; never narrower than one bit.
    function automatic int unsigned debounce_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchronizer plus counter debounce for one button.
// Ports: clock, reset (sync, active-low), btn_raw in; lvl_next, lvl out.
module debounce_cell
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic lvl_next,
    output logic lvl
);

    localparam int unsigned CNT_W = debounce_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        if (sync2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            lvl_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lvl_next = lvl_d;
    assign lvl      = lvl_q;

endmodule

// File: rtl/board_buttons.sv
// board_buttons: debounced, priority-masked start/stop/inc button levels.
// Ports: clock, reset (sync, active-low), start_btn/stop_btn/inc_btn raw in;
// start/stop/inc levels out; start/stop/inc_pulse out with BTN_PULSE_EN.
module board_buttons
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic inc_btn,
    output logic start,
    output logic stop,
`ifdef BTN_PULSE_EN
    output logic inc,
    output logic start_pulse,
    output logic stop_pulse,
    output logic inc_pulse
`else
    output logic inc
`endif
);

    logic [BTN_NUM-1:0] raw;
    logic [BTN_NUM-1:0] lvl_nx;
    logic [BTN_NUM-1:0] lvl_unused;
    logic [BTN_NUM-1:0] out_q, out_d;

    assign raw[BTN_START] = start_btn;
    assign raw[BTN_STOP]  = stop_btn;
    assign raw[BTN_INC]   = inc_btn;

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (raw[i]),
            .lvl_next(lvl_nx[i]),
            .lvl     (lvl_unused[i])
        );
    end

    // Masking uses next-state levels so buttons flipping on the
    // same edge are resolved together, with no transient start.
    always_comb begin
        out_d = '0;
        out_d[BTN_STOP]  = lvl_nx[BTN_STOP];
        out_d[BTN_START] = lvl_nx[BTN_START] & ~lvl_nx[BTN_STOP];
        out_d[BTN_INC]   = lvl_nx[BTN_INC] & ~lvl_nx[BTN_START]
                         & ~lvl_nx[BTN_STOP];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign start = out_q[BTN_START];
    assign stop  = out_q[BTN_STOP];
    assign inc   = out_q[BTN_INC];

`ifdef BTN_PULSE_EN
    logic [BTN_NUM-1:0] prev_q, prev_d;

    always_comb begin
        prev_d = out_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign start_pulse = out_q[BTN_START] & ~prev_q[BTN_START];
    assign stop_pulse  = out_q[BTN_STOP] & ~prev_q[BTN_STOP];
    assign inc_pulse   = out_q[BTN_INC] & ~prev_q[BTN_INC];
`endif

endmodule

// File: tb/tb_board_buttons.sv
// tb_board_buttons: directed + random checks of board_buttons at
// DEBOUNCE_CYCLES 4 and 1 against a history-based reference model.
module tb_board_buttons;

    localparam int MAXE = 4096;

    logic clock;
    logic reset;
    logic start_btn, stop_btn, inc_btn;
    logic start4, stop4, inc4;
    logic start1, stop1, inc1;
`ifdef BTN_PULSE_EN
    logic sp4, tp4, ip4;
    logic sp1, tp1, ip1;
`endif

    board_buttons #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .inc_btn    (inc_btn),
        .start      (start4),
        .stop       (stop4),
`ifdef BTN_PULSE_EN
        .inc        (inc4),
        .start_pulse(sp4),
        .stop_pulse (tp4),
        .inc_pulse  (ip4)
`else
        .inc        (inc4)
`endif
    );

    board_buttons #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .inc_btn    (inc_btn),
        .start      (start1),
        .stop       (stop1),
`ifdef BTN_PULSE_EN
        .inc        (inc1),
        .start_pulse(sp1),
        .stop_pulse (tp1),
        .inc_pulse  (ip1)
`else
        .inc        (inc1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int e = 0;

    // raw_log[k]: buttons {inc,stop,start} present at edge k;
    // rst_log[k]: reset level at edge k (0 = in reset).
    logic [2:0] raw_log [MAXE];
    logic       rst_log [MAXE];

    logic [2:0] m_lvl  [2];
    int         m_last [2][3];
    logic [2:0] m_out  [2];
    logic [2:0] m_prev [2];
    int         m_n    [2];

    // Debounce input seen at edge k: the raw value two edges earlier,
    // or 0 if either synchronizer stage was cleared meanwhile.
    function automatic logic [2:0] smp(input int k);
        if (k < 2) return 3'b000;
        if (!rst_log[k-1] || !rst_log[k-2]) return 3'b000;
        return raw_log[k-2];
    endfunction

    // Level flips once the latest N samples, all taken since the last
    // flip or reset, disagree with it.
    task automatic model_edge(input int d);
        logic [2:0] s;
        logic [2:0] l;
        bit ok;
        m_prev[d] = m_out[d];
        for (int b = 0; b < 3; b++) begin
            if (!rst_log[e]) begin
                m_lvl[d][b] = 1'b0;
                m_last[d][b] = e;
            end else begin
                ok = (e - m_n[d] + 1) > m_last[d][b];
                for (int k = e - m_n[d] + 1; k <= e; k++) begin
                    s = smp(k);
                    if (ok && s[b] == m_lvl[d][b]) ok = 0;
                end
                if (ok) begin
                    m_lvl[d][b] = ~m_lvl[d][b];
                    m_last[d][b] = e;
                end
            end
        end
        l = m_lvl[d];
        if (!rst_log[e]) begin
            m_out[d] = 3'b000;
            m_prev[d] = 3'b000;
        end else begin
            m_out[d][1] = l[1];
            m_out[d][0] = l[0] & ~l[1];
            m_out[d][2] = l[2] & ~l[0] & ~l[1];
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b",
                   tag, e, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] b, input logic r);
        start_btn = b[0];
        stop_btn  = b[1];
        inc_btn   = b[2];
        reset     = r;
        raw_log[e] = b;
        rst_log[e] = r;
        @(posedge clock);
        #1;
        model_edge(0);
        model_edge(1);
        chk("lvl4", {inc4, stop4, start4}, m_out[0]);
        chk("lvl1", {inc1, stop1, start1}, m_out[1]);
`ifdef BTN_PULSE_EN
        chk("pls4", {ip4, tp4, sp4}, m_out[0] & ~m_prev[0]);
        chk("pls1", {ip1, tp1, sp1}, m_out[1] & ~m_prev[1]);
`endif
        if (e < MAXE - 1) e++;
    endtask

    initial begin
        logic [2:0] pat;
        int hold;
        m_n[0] = 4;
        m_n[1] = 1;
        for (int d = 0; d < 2; d++) begin
            m_lvl[d] = 3'b000;
            m_out[d] = 3'b000;
            m_prev[d] = 3'b000;
            for (int b = 0; b < 3; b++) m_last[d][b] = 0;
        end
        start_btn = 0;
        stop_btn = 0;
        inc_btn = 0;
        reset = 0;

        for (int i = 0; i < 3; i++) step(3'b000, 1'b0);
        chk("rst4", {inc4, stop4, start4}, 3'b000);
        for (int i = 0; i < 6; i++) step(3'b000, 1'b1);

        // Clean press of start
        for (int i = 1; i <= 20; i++) begin
            step(3'b001, 1'b1);
            if (i == 5) chk("press_e5", {inc4, stop4, start4}, 3'b000);
            if (i == 6) chk("press_e6", {inc4, stop4, start4}, 3'b001);
`ifdef BTN_PULSE_EN
            if (i == 6) chk("ppulse_e6", {ip4, tp4, sp4}, 3'b001);
            if (i == 7) chk("ppulse_e7", {ip4, tp4, sp4}, 3'b000);
`endif
        end
        for (int i = 0; i < 10; i++) step(3'b000, 1'b1);

        // Bounce on inc, every 2 cycles
        for (int i = 0; i < 16; i++) begin
            step(((i / 2) % 2) != 0 ? 3'b100 : 3'b000, 1'b1);
            chk("bounce", {2'b00, inc4}, 3'b000);
        end
        for (int i = 0; i < 10; i++) step(3'b000, 1'b1);

        // Priority: start and stop together, then stop released
        for (int i = 1; i <= 20; i++) begin
            step(3'b011, 1'b1);
            if (i == 6) chk("prio_e6", {inc4, stop4, start4}, 3'b010);
        end
        for (int i = 1; i <= 20; i++) begin
            step(3'b001, 1'b1);
            if (i == 5) chk("unmask_e5", {inc4, stop4, start4}, 3'b010);
            if (i == 6) chk("unmask_e6", {inc4, stop4, start4}, 3'b001);
        end
        for (int i = 0; i < 10; i++) step(3'b000, 1'b1);

        // Held single-step
        for (int i = 1; i <= 30; i++) begin
            step(3'b100, 1'b1);
            if (i == 6) chk("held_e6", {inc4, stop4, start4}, 3'b100);
        end
        for (int i = 1; i <= 10; i++) begin
            step(3'b000, 1'b1);
            if (i == 5) chk("rel_e5", {inc4, stop4, start4}, 3'b100);
            if (i == 6) chk("rel_e6", {inc4, stop4, start4}, 3'b000);
        end

        // Reset in the middle of a stop debounce
        for (int i = 0; i < 3; i++) step(3'b010, 1'b1);
        step(3'b010, 1'b0);
        chk("midrst", {inc4, stop4, start4}, 3'b000);
        for (int i = 1; i <= 10; i++) begin
            step(3'b010, 1'b1);
            if (i == 5) chk("rst_e5", {inc4, stop4, start4}, 3'b000);
            if (i == 6) chk("rst_e6", {inc4, stop4, start4}, 3'b010);
        end
        for (int i = 0; i < 10; i++) step(3'b000, 1'b1);

        // One-cycle pulse through DEBOUNCE_CYCLES=1
        step(3'b001, 1'b1);
        for (int i = 2; i <= 6; i++) begin
            step(3'b000, 1'b1);
            if (i == 2) chk("min_e2", {inc1, stop1, start1}, 3'b000);
            if (i == 3) chk("min_e3", {inc1, stop1, start1}, 3'b001);
            if (i == 4) chk("min_e4", {inc1, stop1, start1}, 3'b000);
        end

        // Random holds and bounces with occasional reset
        for (int n = 0; n < 120; n++) begin
            pat = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 9);
            for (int i = 0; i < hold; i++) begin
                step(pat, ($urandom_range(0, 60) != 0) ? 1'b1 : 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
